riskv_wb_dbus_master: RTL and testbench
=======================================

# riskv_wb_dbus_master

Parametrised Wishbone classic master for the rv32i data port: converts the core's load/store strobe/busy handshake into single Wishbone cycles. It supports a 32- or 64-bit bus with byte-lane steering, bus-error termination, and an optional cycle timeout, with the faulting address captured. It sits between `rv32i` and the SoC data interconnect, replacing the ad-hoc data-bus glue in the top-level wrapper.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: bus data width; legal values are 32 and 64.
- `TIMEOUT_CYCLES`, 255: cycles allowed in BUS before abort; 0 disables the timeout.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_addr` in ADDR_WIDTH: core byte address.
- `mem_wdata` in 32: store data, pre-aligned within the 32-bit word.
- `mem_wmask` in 4: store byte mask.
- `mem_wstrb` / `mem_rstrb` in 1: store / load request pulse.
- `mem_rdata` out 32: load data.
- `mem_rbusy` / `mem_wbusy` out 1: load / store in progress.
- `bus_fault` out 1: one-cycle pulse on ERR or timeout.
- `fault_addr` out ADDR_WIDTH: address of the last faulting access.
- `fault_we` out 1: last fault was a store.
- `fault_timeout` out 1: last fault was a timeout.
- `wb_adr` out ADDR_WIDTH-log2(DATA_WIDTH/8): word address.
- `wb_dat_mosi` out DATA_WIDTH: write data.
- `wb_sel` out DATA_WIDTH/8: byte selects.
- `wb_cyc`, `wb_stb`, `wb_we` out 1: Wishbone control.
- `wb_dat_miso` in DATA_WIDTH: read data.
- `wb_ack`, `wb_err` in 1: Wishbone termination.

## Operation
- **FSM states:** IDLE, BUS. All outputs are registered.
- **IDLE:** on `mem_rstrb|mem_wstrb`, latch addr, wdata, wmask and we (`we = mem_wstrb`), load the timeout counter, go to BUS.
  - If both strobes are high, the store wins.
  - Strobes arriving in BUS are ignored; the core never issues them while busy.
- **BUS:** `wb_cyc = wb_stb = 1`; `wb_adr`, `wb_we`, `wb_sel` and `wb_dat_mosi` are stable for the whole cycle.
- **Lane steering for DATA_WIDTH=64:**
  - `lane = addr[2]`.
  - Stores: `wb_sel = wmask << 4*lane`; wdata is replicated on both halves.
  - Loads: `wb_sel` = the 4 bits of the addressed half; `mem_rdata` = `wb_dat_miso[32*lane +: 32]`.
- **DATA_WIDTH=32:** loads drive `wb_sel = 4'hF`; stores drive `wb_sel = wmask`.
- **Termination priority:** ERR, then ACK, then timeout.
  - ACK: capture `mem_rdata` on loads only, drop cyc/stb/we, clear busy, go to IDLE.
  - ERR: as ACK, but `mem_rdata <= 0` on loads; pulse `bus_fault`; latch `fault_addr`, `fault_we`, `fault_timeout = 0`.
  - Timeout (counter hits 0, `TIMEOUT_CYCLES != 0`): same as ERR but `fault_timeout = 1`.
- `mem_rdata` holds its value until the next load terminates; stores never change it.
- **Reset values:** every output is 0, including `mem_rdata` and the fault registers. Reset asserted mid-cycle drops `wb_cyc`/`wb_stb` immediately (asynchronous) and returns the FSM to IDLE.

## Timing
- **Cycle numbering:** strobe sampled at edge 0 → cyc/stb/busy high after edge 0.
- **Completion:** ACK sampled at edge N → cyc/stb/busy low and `mem_rdata` valid after edge N. Minimum busy duration is 1 cycle (ACK in the first BUS cycle).
- **Back-to-back:** a new strobe is accepted in the cycle busy is low; there is no dead cycle beyond the IDLE sample.
- **Timeout:** abort after exactly `TIMEOUT_CYCLES` BUS cycles without ACK/ERR. An ACK in the same cycle as expiry wins.
- `bus_fault` is high for exactly the one cycle following termination.

## Structure
- Package `riskv_wb_pkg`:
  - state encoding constants (IDLE, BUS);
  - `WB_SEL_ALL`;
  - `LANE_BITS` helper function `log2(DATA_WIDTH/8)`.
- Sub-module `riskv_wb_timeout`: loadable down-counter with an `expired` output, tied low when `TIMEOUT_CYCLES == 0`. The same counter will be reused by the instruction-bus master.

## Test plan
- DATA_WIDTH=32, load @0x100, slave ACKs after 3 cycles with 0xDEADBEEF → `wb_sel = F`, busy for 3 cycles, `mem_rdata = 0xDEADBEEF`.
- DATA_WIDTH=64, store @0x104, wmask=0x3, wdata=0x0000BEEF → `wb_adr = 0x20`, `wb_sel = 0x30`, `wb_dat_mosi` upper half = 0x0000BEEF, `wb_we = 1`.
- Load @0x200, slave asserts ERR and ACK together → `mem_rdata = 0`, `bus_fault` pulse, `fault_addr = 0x200`, `fault_we = 0`, `fault_timeout = 0`.
- TIMEOUT_CYCLES=4, store with no response → cyc drops after 4 BUS cycles, `fault_timeout = 1`, `fault_we = 1`; an immediately following load completes normally.
- Simultaneous `rstrb` and `wstrb` → a single write cycle; `mem_rdata` unchanged.
- `reset_n` low in the 2nd BUS cycle → `wb_cyc`/`wb_stb`/busy low before the next edge; after release, the next load completes with ACK-in-1.

Source files
------------

// File: rtl/riskv_wb_pkg.sv
// Shared types and helpers for the rv32i Wishbone bus masters.
package riskv_wb_pkg;

   // Bus master FSM: idle, or a single Wishbone classic cycle in flight
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } state_t;

   // Byte selects covering one full 32-bit core word
   localparam logic [3:0] WB_SEL_ALL = 4'hF;

   // Number of byte-offset bits dropped to form the Wishbone word address
   function automatic int LANE_BITS(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/riskv_wb_dbus_master_if.sv
// Wishbone classic bus bundle between the data-bus master and the interconnect.
interface riskv_wb_dbus_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import riskv_wb_pkg::*;

   localparam int LB = LANE_BITS(DATA_WIDTH);

   logic [ADDR_WIDTH-LB-1:0] wb_adr;
   logic [DATA_WIDTH-1:0]    wb_dat_mosi;
   logic [DATA_WIDTH/8-1:0]  wb_sel;
   logic                     wb_cyc;
   logic                     wb_stb;
   logic                     wb_we;
   logic [DATA_WIDTH-1:0]    wb_dat_miso;
   logic                     wb_ack;
   logic                     wb_err;

   modport master (
      output wb_adr, wb_dat_mosi, wb_sel, wb_cyc, wb_stb, wb_we,
      input  wb_dat_miso, wb_ack, wb_err
   );

   modport slave (
      input  wb_adr, wb_dat_mosi, wb_sel, wb_cyc, wb_stb, wb_we,
      output wb_dat_miso, wb_ack, wb_err
   );

endinterface

// File: rtl/riskv_wb_timeout.sv
// Loadable down-counter for bus-cycle watchdogs. Loading CYCLES-1 and flagging
// zero makes the expiry coincide with the CYCLES-th running cycle.
module riskv_wb_timeout #(
   parameter int unsigned CYCLES = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic run,
   output logic expired
);

   generate
      if (CYCLES == 0) begin : g_off
         // Watchdog disabled: never expires
         logic unused_ok;
         assign unused_ok = ^{clk, reset_n, load, run};
         assign expired   = 1'b0;
      end else begin : g_on
         localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

         logic [W-1:0] cnt_q;

         // Reload on a new cycle, count down while the cycle is outstanding
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else if (load) begin
               cnt_q <= W'(CYCLES - 1);
            end else if (run && (cnt_q != '0)) begin
               cnt_q <= cnt_q - 1'b1;
            end
         end

         assign expired = (cnt_q == '0);
      end
   endgenerate

endmodule

// File: rtl/riskv_wb_dbus_master.sv
// rv32i data-port to Wishbone classic master: one single-beat cycle per
// load/store strobe, with lane steering for a 64-bit bus, ERR/timeout abort
// and capture of the faulting access.
module riskv_wb_dbus_master
   import riskv_wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,   // 32 or 64
   parameter int TIMEOUT_CYCLES = 255   // 0 disables the watchdog
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wmask,
   input  logic                  mem_wstrb,
   input  logic                  mem_rstrb,
   output logic [31:0]           mem_rdata,
   output logic                  mem_rbusy,
   output logic                  mem_wbusy,
   output logic                  bus_fault,
   output logic [ADDR_WIDTH-1:0] fault_addr,
   output logic                  fault_we,
   output logic                  fault_timeout,
   riskv_wb_dbus_master_if.master wb
);

   localparam int LB    = LANE_BITS(DATA_WIDTH);
   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int WA_W  = ADDR_WIDTH - LB;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [WA_W-1:0]       wb_adr_q;
   logic [DATA_WIDTH-1:0] wb_dat_q;
   logic [SEL_W-1:0]      wb_sel_q;
   logic                  wb_cyc_q;
   logic                  wb_stb_q;
   logic                  wb_we_q;
   logic [31:0]           mem_rdata_q;
   logic                  rbusy_q;
   logic                  wbusy_q;
   logic                  bus_fault_q;
   logic [ADDR_WIDTH-1:0] fault_addr_q;
   logic                  fault_we_q;
   logic                  fault_timeout_q;

   logic [SEL_W-1:0]      sel_d;
   logic [DATA_WIDTH-1:0] dat_d;
   logic [31:0]           rdata_lane;
   logic                  accept;
   logic                  tmo_expired;
   logic                  terminate;
   logic                  fault_hit;

   // Lane steering: a 64-bit bus places the 32-bit word in the half selected
   // by addr[2]; store data is replicated so either half carries it.
   generate
      if (DATA_WIDTH == 64) begin : g_w64
         logic lane_in;
         assign lane_in    = mem_addr[2];
         assign sel_d      = mem_wstrb
                             ? (lane_in ? {mem_wmask, 4'h0}  : {4'h0, mem_wmask})
                             : (lane_in ? {WB_SEL_ALL, 4'h0} : {4'h0, WB_SEL_ALL});
         assign dat_d      = {mem_wdata, mem_wdata};
         assign rdata_lane = addr_q[2] ? wb.wb_dat_miso[63:32] : wb.wb_dat_miso[31:0];
      end else begin : g_w32
         assign sel_d      = mem_wstrb ? mem_wmask : WB_SEL_ALL;
         assign dat_d      = mem_wdata;
         assign rdata_lane = wb.wb_dat_miso[31:0];
      end
   endgenerate

   // A strobe is only honoured in IDLE; the core never strobes while busy
   assign accept    = (state_q == ST_IDLE) && (mem_rstrb || mem_wstrb);
   assign terminate = wb.wb_err || wb.wb_ack || tmo_expired;
   // ERR always faults; expiry faults only if no ACK arrived in the same cycle
   assign fault_hit = wb.wb_err || (!wb.wb_ack && tmo_expired);

   riskv_wb_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept),
      .run     (state_q == ST_BUS),
      .expired (tmo_expired)
   );

   // Bus FSM: launch a cycle on a strobe, hold it until ERR/ACK/timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         we_q            <= 1'b0;
         wb_adr_q        <= '0;
         wb_dat_q        <= '0;
         wb_sel_q        <= '0;
         wb_cyc_q        <= 1'b0;
         wb_stb_q        <= 1'b0;
         wb_we_q         <= 1'b0;
         mem_rdata_q     <= '0;
         rbusy_q         <= 1'b0;
         wbusy_q         <= 1'b0;
         bus_fault_q     <= 1'b0;
         fault_addr_q    <= '0;
         fault_we_q      <= 1'b0;
         fault_timeout_q <= 1'b0;
      end else begin
         bus_fault_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q  <= ST_BUS;
                  addr_q   <= mem_addr;
                  we_q     <= mem_wstrb;
                  wb_adr_q <= mem_addr[ADDR_WIDTH-1:LB];
                  wb_dat_q <= dat_d;
                  wb_sel_q <= sel_d;
                  wb_cyc_q <= 1'b1;
                  wb_stb_q <= 1'b1;
                  wb_we_q  <= mem_wstrb;
                  rbusy_q  <= !mem_wstrb;
                  wbusy_q  <= mem_wstrb;
               end
            end
            ST_BUS: begin
               if (terminate) begin
                  state_q  <= ST_IDLE;
                  wb_cyc_q <= 1'b0;
                  wb_stb_q <= 1'b0;
                  wb_we_q  <= 1'b0;
                  rbusy_q  <= 1'b0;
                  wbusy_q  <= 1'b0;
                  if (!we_q) begin
                     mem_rdata_q <= fault_hit ? 32'h0 : rdata_lane;
                  end
                  if (fault_hit) begin
                     bus_fault_q     <= 1'b1;
                     fault_addr_q    <= addr_q;
                     fault_we_q      <= we_q;
                     fault_timeout_q <= !wb.wb_err;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wb.wb_adr      = wb_adr_q;
   assign wb.wb_dat_mosi = wb_dat_q;
   assign wb.wb_sel      = wb_sel_q;
   assign wb.wb_cyc      = wb_cyc_q;
   assign wb.wb_stb      = wb_stb_q;
   assign wb.wb_we       = wb_we_q;

   assign mem_rdata     = mem_rdata_q;
   assign mem_rbusy     = rbusy_q;
   assign mem_wbusy     = wbusy_q;
   assign bus_fault     = bus_fault_q;
   assign fault_addr    = fault_addr_q;
   assign fault_we      = fault_we_q;
   assign fault_timeout = fault_timeout_q;

endmodule

// File: tb/tb_riskv_wb_dbus_master.sv
// Directed bench: a 32-bit instance with a 4-cycle watchdog and a 64-bit
// instance with the watchdog disabled, each driven by its own stimulus.
module tb_riskv_wb_dbus_master;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // 32-bit instance (A)
   logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
   logic [3:0]  a_wmask = '0;
   logic        a_wstrb = 1'b0, a_rstrb = 1'b0;
   logic        a_rbusy, a_wbusy, a_fault, a_fwe, a_ftmo;
   logic [31:0] a_faddr;

   // 64-bit instance (B)
   logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
   logic [3:0]  b_wmask = '0;
   logic        b_wstrb = 1'b0, b_rstrb = 1'b0;
   logic        b_rbusy, b_wbusy, b_fault, b_fwe, b_ftmo;
   logic [31:0] b_faddr;

   riskv_wb_dbus_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if32 ();
   riskv_wb_dbus_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) if64 ();

   riskv_wb_dbus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) u32 (
      .clk(clk), .reset_n(reset_n), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .mem_wmask(a_wmask), .mem_wstrb(a_wstrb), .mem_rstrb(a_rstrb),
      .mem_rdata(a_rdata), .mem_rbusy(a_rbusy), .mem_wbusy(a_wbusy),
      .bus_fault(a_fault), .fault_addr(a_faddr), .fault_we(a_fwe),
      .fault_timeout(a_ftmo), .wb(if32)
   );

   riskv_wb_dbus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0)) u64 (
      .clk(clk), .reset_n(reset_n), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .mem_wmask(b_wmask), .mem_wstrb(b_wstrb), .mem_rstrb(b_rstrb),
      .mem_rdata(b_rdata), .mem_rbusy(b_rbusy), .mem_wbusy(b_wbusy),
      .bus_fault(b_fault), .fault_addr(b_faddr), .fault_we(b_fwe),
      .fault_timeout(b_ftmo), .wb(if64)
   );

   initial begin
      if32.wb_dat_miso = '0; if32.wb_ack = 1'b0; if32.wb_err = 1'b0;
      if64.wb_dat_miso = '0; if64.wb_ack = 1'b0; if64.wb_err = 1'b0;
   end

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++; if ({if32.wb_cyc, if32.wb_stb, if32.wb_we, a_rbusy, a_wbusy, a_fault} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl32: got %b expected 000000", {if32.wb_cyc, if32.wb_stb, if32.wb_we, a_rbusy, a_wbusy, a_fault}); end
      checks++; if ({a_rdata, a_faddr, a_fwe, a_ftmo} !== 66'h0) begin
         errors++; $display("FAIL reset_regs32: got rdata=%h faddr=%h fwe=%b ftmo=%b expected all 0", a_rdata, a_faddr, a_fwe, a_ftmo); end
      checks++; if ({if64.wb_cyc, if64.wb_sel, if64.wb_adr, if64.wb_dat_mosi, b_rdata} !== 134'h0) begin
         errors++; $display("FAIL reset_bus64: got cyc=%b sel=%h adr=%h mosi=%h rdata=%h expected all 0", if64.wb_cyc, if64.wb_sel, if64.wb_adr, if64.wb_dat_mosi, b_rdata); end
      reset_n = 1'b1;
      $display("reset: released");
   endtask

   // Load @0x100 on the 32-bit bus, ACK in the 3rd BUS cycle
   task automatic test_load32();
      int busy_cnt = 0;
      @(negedge clk);
      a_addr = 32'h100; a_rstrb = 1'b1;
      @(negedge clk);
      a_rstrb = 1'b0;
      checks++; if (if32.wb_sel !== 4'hF) begin errors++; $display("FAIL load32_sel: got %h expected f", if32.wb_sel); end
      checks++; if (if32.wb_adr !== 30'h40) begin errors++; $display("FAIL load32_adr: got %h expected 40", if32.wb_adr); end
      checks++; if ({if32.wb_cyc, if32.wb_stb, if32.wb_we} !== 3'b110) begin
         errors++; $display("FAIL load32_ctrl: got %b expected 110", {if32.wb_cyc, if32.wb_stb, if32.wb_we}); end
      for (int i = 0; i < 12; i++) begin
         if (!a_rbusy) break;
         busy_cnt++;
         if (busy_cnt == 3) begin if32.wb_ack = 1'b1; if32.wb_dat_miso = 32'hDEADBEEF; end
         @(negedge clk);
      end
      if32.wb_ack = 1'b0; if32.wb_dat_miso = '0;
      checks++; if (busy_cnt !== 3) begin errors++; $display("FAIL load32_busy: got %0d cycles expected 3", busy_cnt); end
      checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load32_rdata: got %h expected deadbeef", a_rdata); end
      checks++; if (if32.wb_cyc !== 1'b0) begin errors++; $display("FAIL load32_cyc_drop: got %b expected 0", if32.wb_cyc); end
      $display("load32: addr=100 rdata=%h busy=%0d", a_rdata, busy_cnt);
   endtask

   // Load @0x200 terminated by ERR and ACK together
   task automatic test_err();
      a_addr = 32'h200; a_rstrb = 1'b1;
      @(negedge clk);
      a_rstrb = 1'b0;
      if32.wb_err = 1'b1; if32.wb_ack = 1'b1; if32.wb_dat_miso = 32'h11111111;
      @(negedge clk);
      if32.wb_err = 1'b0; if32.wb_ack = 1'b0; if32.wb_dat_miso = '0;
      checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL err_rdata: got %h expected 0", a_rdata); end
      checks++; if (a_fault !== 1'b1) begin errors++; $display("FAIL err_fault_pulse: got %b expected 1", a_fault); end
      checks++; if (a_faddr !== 32'h200) begin errors++; $display("FAIL err_faddr: got %h expected 200", a_faddr); end
      checks++; if ({a_fwe, a_ftmo, if32.wb_cyc, a_rbusy} !== 4'b0000) begin
         errors++; $display("FAIL err_flags: got fwe/ftmo/cyc/busy=%b expected 0000", {a_fwe, a_ftmo, if32.wb_cyc, a_rbusy}); end
      @(negedge clk);
      checks++; if (a_fault !== 1'b0) begin errors++; $display("FAIL err_fault_width: got %b expected 0", a_fault); end
      $display("err: faddr=%h fwe=%b ftmo=%b", a_faddr, a_fwe, a_ftmo);
   endtask

   // Store with no response times out after 4 BUS cycles; a load follows at once
   task automatic test_timeout();
      int cyc_cnt = 0;
      a_addr = 32'h300; a_wdata = 32'h55; a_wmask = 4'hF; a_wstrb = 1'b1;
      @(negedge clk);
      a_wstrb = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!if32.wb_cyc) break;
         cyc_cnt++;
         @(negedge clk);
      end
      checks++; if (cyc_cnt !== 4) begin errors++; $display("FAIL tmo_cycles: got %0d expected 4", cyc_cnt); end
      checks++; if ({a_fault, a_ftmo, a_fwe, a_wbusy} !== 4'b1110) begin
         errors++; $display("FAIL tmo_flags: got fault/ftmo/fwe/wbusy=%b expected 1110", {a_fault, a_ftmo, a_fwe, a_wbusy}); end
      checks++; if (a_faddr !== 32'h300) begin errors++; $display("FAIL tmo_faddr: got %h expected 300", a_faddr); end
      a_addr = 32'h104; a_rstrb = 1'b1;
      @(negedge clk);
      a_rstrb = 1'b0;
      checks++; if ({if32.wb_cyc, a_rbusy, a_fault} !== 3'b110) begin
         errors++; $display("FAIL tmo_b2b_start: got cyc/busy/fault=%b expected 110", {if32.wb_cyc, a_rbusy, a_fault}); end
      if32.wb_ack = 1'b1; if32.wb_dat_miso = 32'h12345678;
      @(negedge clk);
      if32.wb_ack = 1'b0; if32.wb_dat_miso = '0;
      checks++; if (a_rdata !== 32'h12345678) begin errors++; $display("FAIL tmo_b2b_rdata: got %h expected 12345678", a_rdata); end
      $display("timeout: cycles=%0d faddr=%h; following load rdata=%h", cyc_cnt, a_faddr, a_rdata);
   endtask

   // ACK arriving in the expiry cycle completes normally
   task automatic test_ack_at_expiry();
      int busy_cnt = 0;
      @(negedge clk);
      a_addr = 32'h108; a_rstrb = 1'b1;
      @(negedge clk);
      a_rstrb = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (!a_rbusy) break;
         busy_cnt++;
         if (busy_cnt == 4) begin if32.wb_ack = 1'b1; if32.wb_dat_miso = 32'h0BADF00D; end
         @(negedge clk);
      end
      if32.wb_ack = 1'b0; if32.wb_dat_miso = '0;
      checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL ackexp_busy: got %0d expected 4", busy_cnt); end
      checks++; if ({a_fault, a_rdata} !== {1'b0, 32'h0BADF00D}) begin
         errors++; $display("FAIL ackexp_result: got fault=%b rdata=%h expected 0 0badf00d", a_fault, a_rdata); end
      checks++; if (a_faddr !== 32'h300) begin errors++; $display("FAIL ackexp_faddr_hold: got %h expected 300", a_faddr); end
      $display("ack_at_expiry: rdata=%h fault=%b", a_rdata, a_fault);
   endtask

   // 64-bit store @0x104 mask 3: upper lane
   task automatic test_store64();
      @(negedge clk);
      b_addr = 32'h104; b_wdata = 32'h0000BEEF; b_wmask = 4'h3; b_wstrb = 1'b1;
      @(negedge clk);
      b_wstrb = 1'b0;
      checks++; if (if64.wb_adr !== 29'h20) begin errors++; $display("FAIL st64_adr: got %h expected 20", if64.wb_adr); end
      checks++; if (if64.wb_sel !== 8'h30) begin errors++; $display("FAIL st64_sel: got %h expected 30", if64.wb_sel); end
      checks++; if (if64.wb_dat_mosi !== 64'h0000BEEF_0000BEEF) begin
         errors++; $display("FAIL st64_mosi: got %h expected 0000beef0000beef", if64.wb_dat_mosi); end
      checks++; if ({if64.wb_we, if64.wb_cyc, b_wbusy, b_rbusy} !== 4'b1110) begin
         errors++; $display("FAIL st64_ctrl: got we/cyc/wbusy/rbusy=%b expected 1110", {if64.wb_we, if64.wb_cyc, b_wbusy, b_rbusy}); end
      if64.wb_ack = 1'b1;
      @(negedge clk);
      if64.wb_ack = 1'b0;
      checks++; if ({if64.wb_cyc, b_wbusy, b_rdata} !== 34'h0) begin
         errors++; $display("FAIL st64_done: got cyc=%b wbusy=%b rdata=%h expected 0 0 0", if64.wb_cyc, b_wbusy, b_rdata); end
      $display("store64: adr=%h sel=%h", 29'h20, 8'h30);
   endtask

   // 64-bit load from the upper lane, then both strobes at once
   task automatic test_both_strobes();
      b_addr = 32'h10C; b_rstrb = 1'b1;
      @(negedge clk);
      b_rstrb = 1'b0;
      checks++; if ({if64.wb_sel, if64.wb_adr} !== {8'hF0, 29'h21}) begin
         errors++; $display("FAIL ld64_sel_adr: got sel=%h adr=%h expected f0 21", if64.wb_sel, if64.wb_adr); end
      if64.wb_ack = 1'b1; if64.wb_dat_miso = 64'hCAFEF00D_11223344;
      @(negedge clk);
      if64.wb_ack = 1'b0; if64.wb_dat_miso = '0;
      checks++; if (b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ld64_rdata: got %h expected cafef00d", b_rdata); end
      b_addr = 32'h108; b_wdata = 32'hAB000000; b_wmask = 4'hC; b_wstrb = 1'b1; b_rstrb = 1'b1;
      @(negedge clk);
      b_wstrb = 1'b0; b_rstrb = 1'b0;
      checks++; if ({if64.wb_we, if64.wb_sel, b_wbusy, b_rbusy} !== {1'b1, 8'h0C, 2'b10}) begin
         errors++; $display("FAIL both_ctrl: got we=%b sel=%h wbusy=%b rbusy=%b expected 1 0c 1 0", if64.wb_we, if64.wb_sel, b_wbusy, b_rbusy); end
      if64.wb_ack = 1'b1; if64.wb_dat_miso = 64'h99999999_99999999;
      @(negedge clk);
      if64.wb_ack = 1'b0; if64.wb_dat_miso = '0;
      checks++; if (b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL both_rdata_hold: got %h expected cafef00d", b_rdata); end
      @(negedge clk);
      checks++; if ({if64.wb_cyc, b_wbusy} !== 2'b00) begin
         errors++; $display("FAIL both_single_cycle: got cyc=%b wbusy=%b expected 0 0", if64.wb_cyc, b_wbusy); end
      $display("both_strobes: single write, rdata=%h", b_rdata);
   endtask

   // Reset asserted in the 2nd BUS cycle, then a load with ACK-in-1
   task automatic test_reset_mid();
      a_addr = 32'h400; a_rstrb = 1'b1;
      @(negedge clk);
      a_rstrb = 1'b0;
      @(negedge clk);
      checks++; if (if32.wb_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_cyc_pre: got %b expected 1", if32.wb_cyc); end
      reset_n = 1'b0;
      #1;
      checks++; if ({if32.wb_cyc, if32.wb_stb, a_rbusy} !== 3'b000) begin
         errors++; $display("FAIL rstmid_drop: got cyc/stb/busy=%b expected 000", {if32.wb_cyc, if32.wb_stb, a_rbusy}); end
      checks++; if ({a_rdata, a_faddr, a_ftmo} !== 65'h0) begin
         errors++; $display("FAIL rstmid_regs: got rdata=%h faddr=%h ftmo=%b expected 0", a_rdata, a_faddr, a_ftmo); end
      @(negedge clk);
      reset_n = 1'b1; a_addr = 32'h500; a_rstrb = 1'b1;
      @(negedge clk);
      a_rstrb = 1'b0;
      checks++; if ({if32.wb_cyc, a_rbusy, if32.wb_adr} !== {2'b11, 30'h140}) begin
         errors++; $display("FAIL rstmid_restart: got cyc=%b busy=%b adr=%h expected 1 1 140", if32.wb_cyc, a_rbusy, if32.wb_adr); end
      if32.wb_ack = 1'b1; if32.wb_dat_miso = 32'h600DCAFE;
      @(negedge clk);
      if32.wb_ack = 1'b0; if32.wb_dat_miso = '0;
      checks++; if ({a_rbusy, a_rdata} !== {1'b0, 32'h600DCAFE}) begin
         errors++; $display("FAIL rstmid_load: got busy=%b rdata=%h expected 0 600dcafe", a_rbusy, a_rdata); end
      $display("reset_mid: recovered, rdata=%h", a_rdata);
   endtask

   initial begin
      test_reset();
      test_load32();
      test_err();
      test_timeout();
      test_ack_at_expiry();
      test_store64();
      test_both_strobes();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
